// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Single-outstanding-request instruction fetch stage. It issues fetch
// requests at the current PC, holds the returned word in an output register
// for decode, and handles redirects from execute. A redirect that arrives
// while a fetch is in flight drains the stale response before fetching again.
//
// Ports
//   Clk                  system clock, rising edge
//   Rst_n                asynchronous active-low reset
//   memRequestOut        one-cycle fetch request pulse to instruction memory
//   memAddressOut        byte address of the request (current PC)
//   memValidIn           memory response strobe, one cycle per request
//   memInstructionIn     instruction word, sampled when memValidIn=1
//   branchTakenIn        redirect request from execute
//   branchTargetIn       redirect byte address (low two bits ignored)
//   stallIn              decode not ready; output register holds
//   instructionOut       fetched instruction to decode
//   pcOut                address of instructionOut
//   pcPlus4Out           pcOut + 4
//   instructionValidOut  output register holds a valid instruction
//   fetchCountOut        consumed-instruction count, present only when
//                        FETCH_PERF_COUNT_EN is defined
//
// Parameter
//   RESET_PC             PC value loaded at reset
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        memRequestOut,
    output logic [31:0] memAddressOut,
    input  logic        memValidIn,
    input  logic [31:0] memInstructionIn,
    input  logic        branchTakenIn,
    input  logic [31:0] branchTargetIn,
    input  logic        stallIn,
    output logic [31:0] instructionOut,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4Out,
    output logic        instructionValidOut
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] fetchCountOut
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic        mem_req;
    logic        consume;

    // Decode takes the held instruction on any edge where it is valid and
    // not stalled, including an edge where a redirect also clears it.
    assign consume = valid_q && !stallIn;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        mem_req    = 1'b0;

        if (consume) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = REQUEST;
            end
            REQUEST: begin
                // The pulse is decoded from the registered state so that the
                // response may arrive in the very next cycle. Only request
                // when the output register will be free to take the reply.
                if (!branchTakenIn && (!valid_q || !stallIn)) begin
                    mem_req = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (branchTakenIn) begin
                    // A coincident response belongs to the old path: drop it.
                    state_d = memValidIn ? REQUEST : DRAIN;
                end else if (memValidIn) begin
                    instr_d    = memInstructionIn;
                    pc_out_d   = pc_q;
                    pc_plus4_d = pc_q + 32'd4;
                    pc_d       = pc_q + 32'd4;
                    valid_d    = 1'b1;
                    state_d    = REQUEST;
                end
            end
            DRAIN: begin
                if (memValidIn) begin
                    state_d = REQUEST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides everything else on PC and validity.
        if (branchTakenIn) begin
            pc_d    = {branchTargetIn[31:2], 2'b00};
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign memRequestOut       = mem_req;
    assign memAddressOut       = pc_q;
    assign instructionOut      = instr_q;
    assign pcOut               = pc_out_q;
    assign pcPlus4Out          = pc_plus4_q;
    assign instructionValidOut = valid_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (consume) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetchCountOut = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// Testbench for instruction_fetch_unit: directed per-cycle vector table,
// hand-written corner sequences (PC wrap, reset during a fetch) and a
// randomized run checked against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;

    // Main DUT (RESET_PC = 0)
    logic        memRequestOut;
    logic [31:0] memAddressOut;
    logic        memValidIn = 1'b0;
    logic [31:0] memInstructionIn = '0;
    logic        branchTakenIn = 1'b0;
    logic [31:0] branchTargetIn = '0;
    logic        stallIn = 1'b0;
    logic [31:0] instructionOut;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4Out;
    logic        instructionValidOut;

    // Second DUT for PC wrap-around (RESET_PC = 0xFFFFFFFC)
    logic        req2;
    logic [31:0] addr2;
    logic        mv2 = 1'b0;
    logic [31:0] md2 = '0;
    logic        br2 = 1'b0;
    logic [31:0] tgt2 = '0;
    logic        st2 = 1'b0;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] pc4_2;
    logic        iv2;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetchCountOut;
    logic [31:0] fetchCount2;
`endif

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk                 (Clk),
        .Rst_n               (Rst_n),
        .memRequestOut       (memRequestOut),
        .memAddressOut       (memAddressOut),
        .memValidIn          (memValidIn),
        .memInstructionIn    (memInstructionIn),
        .branchTakenIn       (branchTakenIn),
        .branchTargetIn      (branchTargetIn),
        .stallIn             (stallIn),
        .instructionOut      (instructionOut),
        .pcOut               (pcOut),
        .pcPlus4Out          (pcPlus4Out),
        .instructionValidOut (instructionValidOut)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .fetchCountOut       (fetchCountOut)
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk                 (Clk),
        .Rst_n               (Rst_n),
        .memRequestOut       (req2),
        .memAddressOut       (addr2),
        .memValidIn          (mv2),
        .memInstructionIn    (md2),
        .branchTakenIn       (br2),
        .branchTargetIn      (tgt2),
        .stallIn             (st2),
        .instructionOut      (instr2),
        .pcOut               (pc2),
        .pcPlus4Out          (pc4_2),
        .instructionValidOut (iv2)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .fetchCountOut       (fetchCount2)
`endif
    );

    always #5 Clk = ~Clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Memory contents: word for byte address a lives at index a/4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h5A00_0000 ^ {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_dut();
        Rst_n = 1'b0;
        memValidIn = 1'b0; memInstructionIn = '0;
        branchTakenIn = 1'b0; branchTargetIn = '0; stallIn = 1'b0;
        mv2 = 1'b0; md2 = '0;
        next_cycle();
        next_cycle();
        Rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        mv;
        logic [31:0] md;
        logic        br;
        logic [31:0] tgt;
        logic        st;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic mv, input logic [31:0] md, input logic br,
                                input logic [31:0] tgt, input logic st, input logic req,
                                input logic [31:0] addr, input logic iv,
                                input logic [31:0] instr, input logic [31:0] pc);
        vec_t v;
        v.mv = mv; v.md = md; v.br = br; v.tgt = tgt; v.st = st;
        v.req = req; v.addr = addr; v.iv = iv; v.instr = instr; v.pc = pc;
        return v;
    endfunction

    vec_t tbl[30];

    // ---------------- reference model state ----------------
    logic        m_started, m_busy, m_stale, m_ov;
    logic [31:0] m_pc, m_oi, m_opc, m_cnt;

    task automatic model_reset();
        m_started = 1'b0; m_busy = 1'b0; m_stale = 1'b0; m_ov = 1'b0;
        m_pc = 32'h0; m_oi = '0; m_opc = '0; m_cnt = '0;
    endtask

    initial begin : main
        logic        pend;
        logic [31:0] paddr;
        int unsigned dly;
        logic [31:0] seen[$];
        logic [31:0] wrap_pc4;
        logic        got_iv;
        logic        exp_req;
        logic        load;

        // rows: mv, md, br, tgt, st | req, addr, iv, instr, pc
        tbl[0]  = mk(0, 0, 0, 0, 0,                         0, 32'h000, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0,                         1, 32'h000, 0, 0, 0);
        tbl[2]  = mk(1, mem_word(32'h000), 0, 0, 0,         0, 32'h000, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,                         1, 32'h004, 1, mem_word(32'h000), 32'h000);
        tbl[4]  = mk(1, mem_word(32'h004), 0, 0, 0,         0, 32'h004, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,                         1, 32'h008, 1, mem_word(32'h004), 32'h004);
        tbl[6]  = mk(1, mem_word(32'h008), 0, 0, 0,         0, 32'h008, 0, 0, 0);
        for (int i = 7; i <= 11; i++)
            tbl[i] = mk(0, 0, 0, 0, 1,                      0, 32'h00C, 1, mem_word(32'h008), 32'h008);
        tbl[12] = mk(0, 0, 0, 0, 0,                         1, 32'h00C, 1, mem_word(32'h008), 32'h008);
        tbl[13] = mk(1, mem_word(32'h00C), 0, 0, 0,         0, 32'h00C, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0,                         1, 32'h010, 1, mem_word(32'h00C), 32'h00C);
        tbl[15] = mk(0, 0, 1, 32'h103, 0,                   0, 32'h010, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0,                         0, 32'h100, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,                         0, 32'h100, 0, 0, 0);
        tbl[18] = mk(1, mem_word(32'h010), 0, 0, 0,         0, 32'h100, 0, 0, 0);
        tbl[19] = mk(1, 32'hBAD0_BAD0, 0, 0, 0,             1, 32'h100, 0, 0, 0);
        tbl[20] = mk(1, mem_word(32'h100), 1, 32'h200, 0,   0, 32'h100, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0,                         1, 32'h200, 0, 0, 0);
        tbl[22] = mk(1, mem_word(32'h200), 0, 0, 0,         0, 32'h200, 0, 0, 0);
        tbl[23] = mk(0, 0, 0, 0, 0,                         1, 32'h204, 1, mem_word(32'h200), 32'h200);
        tbl[24] = mk(1, mem_word(32'h204), 0, 0, 0,         0, 32'h204, 0, 0, 0);
        tbl[25] = mk(0, 0, 1, 32'h300, 1,                   0, 32'h208, 1, mem_word(32'h204), 32'h204);
        tbl[26] = mk(0, 0, 0, 0, 1,                         1, 32'h300, 0, 0, 0);
        tbl[27] = mk(1, mem_word(32'h300), 0, 0, 1,         0, 32'h300, 0, 0, 0);
        tbl[28] = mk(0, 0, 0, 0, 1,                         0, 32'h304, 1, mem_word(32'h300), 32'h300);
        tbl[29] = mk(0, 0, 0, 0, 0,                         1, 32'h304, 1, mem_word(32'h300), 32'h300);

        // ---------- phase 1: directed table ----------
        reset_dut();
        for (int i = 0; i < 30; i++) begin
            memValidIn       = tbl[i].mv;
            memInstructionIn = tbl[i].md;
            branchTakenIn    = tbl[i].br;
            branchTargetIn   = tbl[i].tgt;
            stallIn          = tbl[i].st;
            @(negedge Clk);
            chk($sformatf("vec%0d_req", i), {31'b0, memRequestOut}, {31'b0, tbl[i].req});
            chk($sformatf("vec%0d_addr", i), memAddressOut, tbl[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, instructionValidOut}, {31'b0, tbl[i].iv});
            if (tbl[i].iv) begin
                chk($sformatf("vec%0d_instr", i), instructionOut, tbl[i].instr);
                chk($sformatf("vec%0d_pc", i), pcOut, tbl[i].pc);
                chk($sformatf("vec%0d_pc4", i), pcPlus4Out, tbl[i].pc + 32'd4);
            end
            next_cycle();
        end
        memValidIn = 1'b0; branchTakenIn = 1'b0; stallIn = 1'b0;

        // ---------- phase 2: PC wrap on the second instance ----------
        reset_dut();
        pend = 1'b0; paddr = '0; got_iv = 1'b0; wrap_pc4 = 32'hDEAD_DEAD;
        for (int c = 0; c < 8; c++) begin
            mv2 = pend;
            md2 = mem_word(paddr);
            pend = 1'b0;
            @(negedge Clk);
            if (req2) begin
                seen.push_back(addr2);
                paddr = addr2;
                pend = 1'b1;
            end
            if (iv2 && !got_iv) begin
                got_iv = 1'b1;
                chk("wrap_first_pc", pc2, 32'hFFFF_FFFC);
                wrap_pc4 = pc4_2;
            end
            next_cycle();
        end
        mv2 = 1'b0;
        chk("wrap_req_count_ge2", {31'b0, seen.size() >= 2}, 32'd1);
        if (seen.size() >= 2) begin
            chk("wrap_first_addr", seen[0], 32'hFFFF_FFFC);
            chk("wrap_second_addr", seen[1], 32'h0000_0000);
        end
        chk("wrap_pc_plus4", wrap_pc4, 32'h0000_0000);

        // ---------- phase 3: asynchronous reset during WAIT ----------
        reset_dut();
        next_cycle();                                   // IDLE
        next_cycle();                                   // REQUEST, addr 0
        memValidIn = 1'b1; memInstructionIn = mem_word(32'h0);
        next_cycle();                                   // delivered next edge
        memValidIn = 1'b0;
        @(negedge Clk);
        chk("rst_pre_valid", {31'b0, instructionValidOut}, 32'd1);
        chk("rst_pre_req", {31'b0, memRequestOut}, 32'd1);
        next_cycle();                                   // now in WAIT, request outstanding
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_async_req", {31'b0, memRequestOut}, 32'd0);
        chk("rst_async_addr", memAddressOut, 32'h0);
        chk("rst_async_instr", instructionOut, 32'h0);
        chk("rst_async_pc", pcOut, 32'h0);
        chk("rst_async_pc4", pcPlus4Out, 32'h0);
        chk("rst_async_valid", {31'b0, instructionValidOut}, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        chk("rst_async_count", fetchCountOut, 32'h0);
`endif
        next_cycle();
        Rst_n = 1'b1;
        // Late response to the abandoned fetch lands in IDLE and is ignored.
        memValidIn = 1'b1; memInstructionIn = 32'hBAD0_0001;
        @(negedge Clk);
        chk("rst_idle_req", {31'b0, memRequestOut}, 32'd0);
        chk("rst_idle_valid", {31'b0, instructionValidOut}, 32'd0);
        next_cycle();
        memValidIn = 1'b0;
        @(negedge Clk);
        chk("rst_restart_req", {31'b0, memRequestOut}, 32'd1);
        chk("rst_restart_addr", memAddressOut, 32'h0);
        chk("rst_restart_valid", {31'b0, instructionValidOut}, 32'd0);
        next_cycle();
        memValidIn = 1'b1; memInstructionIn = mem_word(32'h0);
        next_cycle();
        memValidIn = 1'b0;
        @(negedge Clk);
        chk("rst_restart_instr", instructionOut, mem_word(32'h0));
        chk("rst_restart_pc", pcOut, 32'h0);
        next_cycle();

        // ---------- phase 4: randomized run vs reference model ----------
        reset_dut();
        model_reset();
        pend = 1'b0; paddr = '0; dly = 0;
        for (int c = 0; c < 3000; c++) begin
            // responder: one reply per request after 1..4 cycles
            memValidIn = 1'b0;
            if (pend) begin
                if (dly <= 1) begin
                    memValidIn = 1'b1;
                    memInstructionIn = mem_word(paddr);
                    pend = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (!memValidIn) memInstructionIn = $urandom;
            stallIn       = ($urandom_range(0, 3) == 0);
            branchTakenIn = ($urandom_range(0, 15) == 0);
            branchTargetIn = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom);
            @(negedge Clk);

            exp_req = m_started && !m_busy && !branchTakenIn && (!m_ov || !stallIn);
            chk("rnd_req", {31'b0, memRequestOut}, {31'b0, exp_req});
            chk("rnd_addr", memAddressOut, m_pc);
            chk("rnd_valid", {31'b0, instructionValidOut}, {31'b0, m_ov});
            if (m_ov) begin
                chk("rnd_instr", instructionOut, m_oi);
                chk("rnd_pc", pcOut, m_opc);
                chk("rnd_pc4", pcPlus4Out, m_opc + 32'd4);
            end
`ifdef FETCH_PERF_COUNT_EN
            chk("rnd_count", fetchCountOut, m_cnt);
`endif
            if (memRequestOut) begin
                pend = 1'b1;
                paddr = memAddressOut;
                dly = $urandom_range(1, 4);
            end

            // model update for this edge
            if (m_ov && !stallIn) m_cnt = m_cnt + 32'd1;
            load = m_busy && memValidIn && !m_stale && !branchTakenIn;
            if (branchTakenIn) begin
                m_pc = {branchTargetIn[31:2], 2'b00};
                m_ov = 1'b0;
                if (m_busy) begin
                    if (memValidIn) begin
                        m_busy = 1'b0; m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else begin
                if (load) begin
                    m_oi  = memInstructionIn;
                    m_opc = m_pc;
                    m_pc  = m_pc + 32'd4;
                    m_ov  = 1'b1;
                end else if (m_ov && !stallIn) begin
                    m_ov = 1'b0;
                end
                if (m_busy && memValidIn) begin
                    m_busy = 1'b0; m_stale = 1'b0;
                end
                if (exp_req) m_busy = 1'b1;
            end
            m_started = 1'b1;
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
